dmem_responder: RTL and testbench

- Memory-side responder for the single-cycle CPU's data port (data_addr / write_data / we in, dmemdata out).
- Word-addressed RAM with combinational read and synchronous write, plus a small MMIO window.
- MMIO window holds an LED register, a status register, and a transmit FIFO that a downstream sink drains over a valid/ready handshake.
- Sits beside the CPU at top level; the CPU sees one-cycle memory with no stalls.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_responder_sync_fifo.sv | 47 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO decode and STATUS layout.
package dmem_responder_pkg;

   localparam int MMIO_SEL_BIT = 31;

   localparam logic [1:0] ADDR_TXDATA = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_LED    = 2'd2;
   localparam logic [1:0] ADDR_CYCLE  = 2'd3;

   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_OVERFLOW  = 2;
   localparam int STAT_COUNT_LSB = 4;

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with FIFO_AW+1 bit pointers; the extra MSB separates full from empty.
module sync_fifo #(
   parameter int WIDTH   = 32,
   parameter int FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [WIDTH-1:0]   push_data,
   input  logic               pop,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   count,
   output logic [WIDTH-1:0]   head
);

   logic [WIDTH-1:0] mem [2**FIFO_AW];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic             do_pop;
   logic             do_push;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
   end

   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: rtl/dmem_responder.sv
// CPU data-port responder: word RAM plus MMIO (TX FIFO, STATUS, LED, CYCLE).
// Optional cycle counter is built when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int RAM_AW  = 8,
   parameter int FIFO_AW = 3,
   parameter int LED_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      data_addr,
   input  logic [31:0]      write_data,
   input  logic             we,
   output logic [31:0]      dmemdata,
   output logic [31:0]      tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [LED_W-1:0] led
);

   logic [31:0]       ram [2**RAM_AW];
   logic              mmio_sel;
   logic [1:0]        mmio_off;
   logic [RAM_AW-1:0] ram_idx;
   logic              wr_en;
   logic              push_req;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_AW:0]  fifo_count;
   logic              overflow;
   logic              overflow_set;
   logic [31:0]       status_word;
   logic [31:0]       cycle_rd;
   logic              unused_addr;

   assign mmio_sel    = data_addr[MMIO_SEL_BIT];
   assign mmio_off    = data_addr[1:0];
   assign ram_idx     = data_addr[RAM_AW-1:0];
   assign unused_addr = ^data_addr[30:RAM_AW];

   assign wr_en        = we && !reset;
   assign push_req     = wr_en && mmio_sel && (mmio_off == ADDR_TXDATA);
   assign pop          = tx_valid && tx_ready;
   assign overflow_set = push_req && fifo_full && !pop;

   sync_fifo #(
      .WIDTH   (32),
      .FIFO_AW (FIFO_AW)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (write_data),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (tx_data)
   );

   assign tx_valid = !fifo_empty;

   always_ff @(posedge clk) begin
      if (wr_en && !mmio_sel) ram[ram_idx] <= write_data;
   end

   // A rejected push in the same cycle as a STATUS write keeps overflow set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (overflow_set) begin
         overflow <= 1'b1;
      end else if (wr_en && mmio_sel && (mmio_off == ADDR_STATUS)) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led <= '0;
      end else if (wr_en && mmio_sel && (mmio_off == ADDR_LED)) begin
         led <= write_data[LED_W-1:0];
      end
   end

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;

   // A load still counts this cycle, so the next read sees write_data+1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
      end else if (wr_en && mmio_sel && (mmio_off == ADDR_CYCLE)) begin
         cycle_cnt <= write_data + 32'd1;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   assign cycle_rd = cycle_cnt;
`else
   assign cycle_rd = '0;
`endif

   always_comb begin
      status_word                                 = '0;
      status_word[STAT_FULL]                      = fifo_full;
      status_word[STAT_EMPTY]                     = fifo_empty;
      status_word[STAT_OVERFLOW]                  = overflow;
      status_word[STAT_COUNT_LSB+FIFO_AW:STAT_COUNT_LSB] = fifo_count;
   end

   always_comb begin
      dmemdata = '0;
      if (!mmio_sel) begin
         dmemdata = ram[ram_idx];
      end else begin
         case (mmio_off)
            ADDR_TXDATA: dmemdata = '0;
            ADDR_STATUS: dmemdata = status_word;
            ADDR_LED:    dmemdata = 32'(led);
            default:     dmemdata = cycle_rd;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue-based reference model plus directed vectors.
module tb_dmem_responder;

   localparam int DEPTH = 8;

   localparam logic [31:0] A_TX   = 32'h8000_0000;
   localparam logic [31:0] A_STAT = 32'h8000_0001;
   localparam logic [31:0] A_LED  = 32'h8000_0002;
   localparam logic [31:0] A_CYC  = 32'h8000_0003;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_addr = '0;
   logic [31:0] write_data = '0;
   logic        we = 1'b0;
   logic        tx_ready = 1'b0;
   logic [31:0] dmemdata;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic [15:0] led;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [31:0] ram_m [256];
   bit          ram_w [256];
   logic [31:0] q [$];
   bit          ovf_m = 1'b0;
   logic [15:0] led_m = '0;
   logic [31:0] cyc_m = '0;

   dmem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .data_addr  (data_addr),
      .write_data (write_data),
      .we         (we),
      .dmemdata   (dmemdata),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .led        (led)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] status_m();
      int sz;
      sz = q.size();
      return 32'(sz * 16 + (ovf_m ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == DEPTH ? 1 : 0));
   endfunction

   always @(posedge clk) begin : model_update
      bit pop_m;
      bit is_mmio;
      int sz;
      if (reset) begin
         q.delete();
         ovf_m = 1'b0;
         led_m = '0;
         cyc_m = '0;
      end else begin
         sz      = q.size();
         pop_m   = (sz > 0) && tx_ready;
         is_mmio = data_addr[31];
`ifdef DMEM_CYCLE_COUNTER_EN
         if (we && is_mmio && data_addr[1:0] == 2'd3) cyc_m = write_data + 1;
         else cyc_m = cyc_m + 1;
`endif
         if (we && is_mmio && data_addr[1:0] == 2'd1) ovf_m = 1'b0;
         if (pop_m) void'(q.pop_front());
         if (we && is_mmio && data_addr[1:0] == 2'd0) begin
            if (sz < DEPTH || pop_m) q.push_back(write_data);
            else ovf_m = 1'b1;
         end
         if (we && is_mmio && data_addr[1:0] == 2'd2) led_m = write_data[15:0];
         if (we && !is_mmio) begin
            ram_m[data_addr[7:0]] = write_data;
            ram_w[data_addr[7:0]] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (!data_addr[31]) begin
            if (ram_w[data_addr[7:0]]) check32("cmp_dmem_ram", dmemdata, ram_m[data_addr[7:0]]);
         end else begin
            case (data_addr[1:0])
               2'd0: check32("cmp_dmem_txdata", dmemdata, 32'h0);
               2'd1: check32("cmp_dmem_status", dmemdata, status_m());
               2'd2: check32("cmp_dmem_led", dmemdata, {16'h0, led_m});
               default: check32("cmp_dmem_cycle", dmemdata, cyc_m);
            endcase
         end
         check32("cmp_tx_valid", {31'h0, tx_valid}, {31'h0, q.size() != 0});
         if (q.size() != 0) check32("cmp_tx_data", tx_data, q[0]);
         check32("cmp_led", {16'h0, led}, {16'h0, led_m});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      data_addr  = a;
      write_data = d;
      we         = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      data_addr = a;
      we        = 1'b0;
      @(negedge clk);
      check32(name, dmemdata, exp);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (ram_w[i]) ram_w[i] = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset  = 1'b0;
      chk_en = 1'b1;

      // RAM store/load and aliasing
      wr(32'h5, 32'hDEAD_BEEF);
      rd("ram_load_5", 32'h5, 32'hDEAD_BEEF);
      rd("ram_alias_105", 32'h105, 32'hDEAD_BEEF);

      // three pushes, then drain
      tx_ready = 1'b0;
      wr(A_TX, 32'h11);
      wr(A_TX, 32'h22);
      wr(A_TX, 32'h33);
      rd("status_three", A_STAT, 32'h30);
      tx_ready  = 1'b1;
      data_addr = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check32("drain3_tx_data", tx_data, 32'h11 * (i + 1));
         step();
      end
      @(negedge clk);
      check32("drain3_tx_valid", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      step();
      rd("status_drained", A_STAT, 32'h2);

      // fill, overflow, clear
      for (int i = 0; i < 8; i++) wr(A_TX, 32'h100 + i);
      rd("status_full", A_STAT, 32'h81);
      wr(A_TX, 32'h999);
      rd("status_overflow", A_STAT, 32'h85);
      wr(A_STAT, 32'h0);
      rd("status_ovf_clear", A_STAT, 32'h81);

      // push into full FIFO while popping
      tx_ready   = 1'b1;
      data_addr  = A_TX;
      write_data = 32'hAA;
      we         = 1'b1;
      @(negedge clk);
      check32("full_pop_head", tx_data, 32'h100);
      step();
      we       = 1'b0;
      tx_ready = 1'b0;
      rd("status_push_pop_full", A_STAT, 32'h81);
      tx_ready  = 1'b1;
      data_addr = 32'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check32("drain8_tx_data", tx_data, (i < 7) ? 32'h101 + i : 32'hAA);
         step();
      end
      tx_ready = 1'b0;
      rd("status_drained2", A_STAT, 32'h2);

      // LED, then reset mid-transfer
      wr(A_LED, 32'h0000_00A5);
      data_addr = A_LED;
      @(negedge clk);
      check32("led_out", {16'h0, led}, 32'hA5);
      check32("led_load", dmemdata, 32'hA5);
      step();
      for (int i = 0; i < 3; i++) wr(A_TX, 32'h201 + i);
      reset      = 1'b1;
      tx_ready   = 1'b1;
      data_addr  = 32'h5;
      write_data = 32'h1234_5678;
      we         = 1'b1;
      step();
      reset    = 1'b0;
      we       = 1'b0;
      tx_ready = 1'b0;
      @(negedge clk);
      check32("reset_led", {16'h0, led}, 32'h0);
      check32("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      step();
      rd("reset_status", A_STAT, 32'h2);
      rd("reset_ram_kept", 32'h5, 32'hDEAD_BEEF);

      // cycle counter
      wr(A_CYC, 32'hFFFF_FFFE);
`ifdef DMEM_CYCLE_COUNTER_EN
      rd("cycle_first", A_CYC, 32'hFFFF_FFFF);
      rd("cycle_wrap", A_CYC, 32'h0);
`else
      rd("cycle_off_first", A_CYC, 32'h0);
      rd("cycle_off_second", A_CYC, 32'h0);
`endif

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
